// File: rtl/rsg_pkg.sv
// Shared types and width helpers for the READY->SET->GO start sequencer.
package rsg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SET   = 2'd2,
    GO    = 2'd3
  } seq_state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsg_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping from N-1 back to 0.
module rr_arbiter
  import rsg_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx
);

  // Scan N positions starting at the pointer and keep the first hit.
  always_comb begin
    int   pos;
    logic found;
    pos   = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = PTR_W'(pos);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rsg_sequencer.sv
// Round-robin scheduler for a shared READY->SET->GO start sequence with
// programmable per-phase dwell and a one-cycle completion pulse to the owner.
module rsg_sequencer
  import rsg_pkg::*;
#(
  parameter int N            = 4,
  parameter int READY_CYCLES = 2,
  parameter int SET_CYCLES   = 3,
  parameter int GO_CYCLES    = 1
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic [N-1:0] req,
  input  logic         abort,
  output logic [N-1:0] grant,
  output logic         get_ready,
  output logic         get_set,
  output logic         get_going,
  output logic [N-1:0] done,
  output logic         busy
);

  localparam int CNT_W = $clog2(max_of3(READY_CYCLES, SET_CYCLES, GO_CYCLES) + 1);
  localparam int PTR_W = idx_width(N);

  seq_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [PTR_W-1:0] ptr_r, ptr_s;
  logic [PTR_W-1:0] owner_r, owner_s;
  logic [N-1:0]     grant_r, grant_s;
  logic [N-1:0]     done_r, done_s;
  logic             ready_r, set_r, going_r, busy_r;

  logic [N-1:0]     arb_grant_s;
  logic [PTR_W-1:0] arb_idx_s;
  logic [PTR_W-1:0] ptr_adv_s;
  logic             owner_req_s;

  rr_arbiter #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s)
  );

  assign owner_req_s = req[owner_r];
  assign ptr_adv_s   = (owner_r == PTR_W'(N - 1)) ? '0 : owner_r + PTR_W'(1);

  // Next-state: arbitration in IDLE, dwell countdown, early exit on abort/withdrawal.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    grant_s = grant_r;
    done_s  = '0;
    case (state_r)
      IDLE: begin
        if (!abort && (|req)) begin
          state_s = READY;
          cnt_s   = CNT_W'(READY_CYCLES);
          owner_s = arb_idx_s;
          grant_s = arb_grant_s;
        end else begin
          grant_s = '0;
        end
      end
      READY, SET, GO: begin
        if (abort || !owner_req_s) begin
          state_s = IDLE;
          cnt_s   = '0;
          grant_s = '0;
          ptr_s   = ptr_adv_s;
        end else if (cnt_r > CNT_W'(1)) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          case (state_r)
            READY: begin
              state_s = SET;
              cnt_s   = CNT_W'(SET_CYCLES);
            end
            SET: begin
              state_s = GO;
              cnt_s   = CNT_W'(GO_CYCLES);
            end
            default: begin
              state_s = IDLE;
              cnt_s   = '0;
              grant_s = '0;
              ptr_s   = ptr_adv_s;
              done_s  = grant_r;
            end
          endcase
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        grant_s = '0;
      end
    endcase
  end

  // State, counter, pointer and registered output decode.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ptr_r   <= '0;
      owner_r <= '0;
      grant_r <= '0;
      done_r  <= '0;
      ready_r <= 1'b0;
      set_r   <= 1'b0;
      going_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      ready_r <= (state_s == READY);
      set_r   <= (state_s == SET);
      going_r <= (state_s == GO);
      busy_r  <= (state_s != IDLE);
    end
  end

  assign grant     = grant_r;
  assign done      = done_r;
  assign get_ready = ready_r;
  assign get_set   = set_r;
  assign get_going = going_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rsg_sequencer.sv
// Bench for rsg_sequencer: elapsed-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rsg_sequencer;

  localparam int N     = 4;
  localparam int RC    = 2;
  localparam int SC    = 3;
  localparam int GC    = 1;
  localparam int TOTAL = RC + SC + GC;

  logic         clock;
  logic         resetN;
  logic [N-1:0] req;
  logic         abort;
  logic [N-1:0] grant;
  logic         get_ready;
  logic         get_set;
  logic         get_going;
  logic [N-1:0] done;
  logic         busy;

  int checks;
  int errors;

  int m_active;
  int m_owner;
  int m_elapsed;
  int m_ptr;
  int m_done;

  rsg_sequencer #(
    .N            (N),
    .READY_CYCLES (RC),
    .SET_CYCLES   (SC),
    .GO_CYCLES    (GC)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .req       (req),
    .abort     (abort),
    .grant     (grant),
    .get_ready (get_ready),
    .get_set   (get_set),
    .get_going (get_going),
    .done      (done),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: a sequence is an owner plus elapsed cycles since its start.
  initial begin
    m_active = 0; m_owner = 0; m_elapsed = 0; m_ptr = 0; m_done = -1;
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) begin
        m_active = 0; m_owner = 0; m_elapsed = 0; m_ptr = 0; m_done = -1;
      end else begin
        m_done = -1;
        if (m_active != 0) begin
          if (abort || !req[m_owner]) begin
            m_active = 0;
            m_ptr    = (m_owner + 1) % N;
          end else if (m_elapsed == TOTAL - 1) begin
            m_active = 0;
            m_done   = m_owner;
            m_ptr    = (m_owner + 1) % N;
          end else begin
            m_elapsed++;
          end
        end else if (!abort && req != '0) begin
          for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              break;
            end
          end
          m_active  = 1;
          m_elapsed = 0;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    logic [N-1:0] e_grant;
    logic [N-1:0] e_done;
    logic         e_rdy, e_set, e_go, e_busy;
    forever begin
      @(negedge clock);
      if (resetN) begin
        e_grant = (m_active != 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_done  = (m_done >= 0) ? (4'b0001 << m_done) : 4'b0000;
        e_rdy   = (m_active != 0) && (m_elapsed < RC);
        e_set   = (m_active != 0) && (m_elapsed >= RC) && (m_elapsed < RC + SC);
        e_go    = (m_active != 0) && (m_elapsed >= RC + SC);
        e_busy  = (m_active != 0);
        lit("model", {2'b00, grant, done, get_ready, get_set, get_going, busy, 2'b00},
                     {2'b00, e_grant, e_done, e_rdy, e_set, e_go, e_busy, 2'b00});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    req    = '0;
    abort  = 1'b0;
    #1;
    lit("reset_out", {grant, done, get_ready, get_set, get_going, busy, 4'h0}, 16'h0000);
    cyc(3);
    resetN = 1'b1;

    // 1: idle with no requests
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      lit("idle_out", {grant, done, get_ready, get_set, get_going, busy, 4'h0}, 16'h0000);
    end

    // 2: single requester full sequence
    req = 4'b0001;
    cyc(1); lit("s2_grant", 16'(grant), 16'h0001); lit("s2_ready1", 16'(get_ready), 16'h0001);
    cyc(1); lit("s2_ready2", 16'(get_ready), 16'h0001);
    cyc(1); lit("s2_set1", 16'(get_set), 16'h0001);
    cyc(2); lit("s2_set3", 16'(get_set), 16'h0001);
    cyc(1); lit("s2_go", 16'(get_going), 16'h0001);
    cyc(1); lit("s2_done", 16'(done), 16'h0001); lit("s2_gnt0", 16'(grant), 16'h0000);
    lit("s2_busy0", 16'(busy), 16'h0000);
    req = '0;
    cyc(1); lit("s2_done_end", 16'(done), 16'h0000);

    // 3: two requesters alternate with one idle cycle between sequences
    req = 4'b1010;
    cyc(1); lit("s3_own1", 16'(grant), 16'h0002);
    cyc(6); lit("s3_done1", 16'(done), 16'h0002); lit("s3_gap1", 16'(busy), 16'h0000);
    cyc(1); lit("s3_own2", 16'(grant), 16'h0008);
    cyc(6); lit("s3_done2", 16'(done), 16'h0008);
    cyc(1); lit("s3_own3", 16'(grant), 16'h0002);
    req = '0;
    cyc(2);

    // 4: withdrawal mid-SET, then pointer wraps past 3 to 0
    req = 4'b0100;
    cyc(1); lit("s4_own", 16'(grant), 16'h0004);
    cyc(3); lit("s4_set2", 16'(get_set), 16'h0001);
    req = '0;
    cyc(1); lit("s4_idle", {8'h00, grant, done}, 16'h0000); lit("s4_busy", 16'(busy), 16'h0000);
    req = 4'b0101;
    cyc(1); lit("s4_wrap", 16'(grant), 16'h0001);
    req = '0;
    cyc(2);

    // 5: abort on the final GO cycle suppresses done
    req = 4'b0001;
    cyc(6); lit("s5_go", 16'(get_going), 16'h0001);
    abort = 1'b1;
    cyc(1); lit("s5_nodone", 16'(done), 16'h0000); lit("s5_busy", 16'(busy), 16'h0000);
    abort = 1'b0;
    req   = '0;
    cyc(2);

    // 6: asynchronous reset mid-SET restores pointer 0
    req = 4'b0100;
    cyc(4); lit("s6_set", 16'(get_set), 16'h0001);
    #2 resetN = 1'b0;
    #1 lit("s6_rst", {grant, done, get_ready, get_set, get_going, busy, 4'h0}, 16'h0000);
    req = 4'b1001;
    cyc(1);
    resetN = 1'b1;
    cyc(1); lit("s6_ptr0", 16'(grant), 16'h0001);
    req = '0;
    cyc(2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if ($urandom_range(0, 7) == 0) begin
        req = 4'($urandom);
      end else begin
        req = req;
      end
      abort = ($urandom_range(0, 15) == 0);
    end
    abort = 1'b0;
    req   = '0;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
